// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified main-memory arbiter.
// State and owner encodings, the streak-counter width and the saturating streak increment.
package mem_arbiter_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_I_BUSY = 2'b01,
    ARB_D_BUSY = 2'b10,
    ARB_RESP   = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Saturating increment of the consecutive-D-grant counter.
  function automatic logic [STREAK_W-1:0] streak_sat_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] lim
  );
    logic [STREAK_W-1:0] res;
    if (cur >= lim) begin
      res = lim;
    end else begin
      res = cur + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-side, D-side and main-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the view of its environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_rdy;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_rdy;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdata, i_rdy, d_rdata, d_rdy, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdata, i_rdy, d_rdata, d_rdy, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_grant.sv
// Combinational winner select: D wins unless I is waiting and D has used up its streak.
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] d_streak,
  output logic                grant_i,
  output logic                grant_d
);

  localparam logic [STREAK_W-1:0] LIM_C = STREAK_W'(STARVE_LIM);

  // Priority select with starvation override.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req && (!i_req || (d_streak < LIM_C))) begin
      grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Unified main-memory arbiter between I-cache fill and D-cache miss/write-back paths.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int LINE_W     = 64,
  parameter int STARVE_LIM = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] LIM_C = STREAK_W'(STARVE_LIM);

  arb_state_e          state_r, state_nx_s;
  arb_owner_e          owner_r, owner_nx_s;
  logic [STREAK_W-1:0] d_streak_r, d_streak_nx_s;
  logic                mem_re_r, mem_re_nx_s;
  logic                mem_we_r, mem_we_nx_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nx_s;
  logic [LINE_W-1:0]   mem_wdata_r, mem_wdata_nx_s;
  logic [LINE_W-1:0]   i_rdata_r, i_rdata_nx_s;
  logic [LINE_W-1:0]   d_rdata_r, d_rdata_nx_s;
  logic                i_rdy_r, i_rdy_nx_s;
  logic                d_rdy_r, d_rdy_nx_s;
  logic                grant_i_s, grant_d_s;

  mem_arbiter_grant #(.STARVE_LIM(STARVE_LIM)) u_grant (
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .d_streak (d_streak_r),
    .grant_i  (grant_i_s),
    .grant_d  (grant_d_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (grant_d_s) begin
          state_nx_s = ARB_D_BUSY;
        end else if (grant_i_s) begin
          state_nx_s = ARB_I_BUSY;
        end else begin
          state_nx_s = ARB_IDLE;
        end
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        if (bus.mem_rdy) begin
          state_nx_s = ARB_RESP;
        end else begin
          state_nx_s = state_r;
        end
      end
      ARB_RESP: state_nx_s = ARB_IDLE;
      default:  state_nx_s = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs, owner and streak counter.
  always_comb begin
    owner_nx_s     = owner_r;
    d_streak_nx_s  = d_streak_r;
    mem_re_nx_s    = mem_re_r;
    mem_we_nx_s    = mem_we_r;
    mem_addr_nx_s  = mem_addr_r;
    mem_wdata_nx_s = mem_wdata_r;
    i_rdata_nx_s   = i_rdata_r;
    d_rdata_nx_s   = d_rdata_r;
    i_rdy_nx_s     = 1'b0;
    d_rdy_nx_s     = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (grant_d_s) begin
          owner_nx_s     = OWN_D;
          mem_addr_nx_s  = bus.d_addr;
          mem_wdata_nx_s = bus.d_wdata;
          mem_we_nx_s    = bus.d_we;
          mem_re_nx_s    = ~bus.d_we;
          if (bus.i_req) begin
            d_streak_nx_s = streak_sat_inc(d_streak_r, LIM_C);
          end else begin
            d_streak_nx_s = 4'd0;
          end
        end else if (grant_i_s) begin
          owner_nx_s    = OWN_I;
          mem_addr_nx_s = bus.i_addr;
          mem_re_nx_s   = 1'b1;
          mem_we_nx_s   = 1'b0;
          d_streak_nx_s = 4'd0;
        end else begin
          mem_re_nx_s = 1'b0;
          mem_we_nx_s = 1'b0;
        end
      end
      ARB_I_BUSY, ARB_D_BUSY: begin
        if (bus.mem_rdy) begin
          mem_re_nx_s = 1'b0;
          mem_we_nx_s = 1'b0;
          // Only reads update the owner's rdata; a write-back leaves d_rdata alone.
          if (owner_r == OWN_D) begin
            d_rdy_nx_s = 1'b1;
            if (mem_re_r) begin
              d_rdata_nx_s = bus.mem_rdata;
            end else begin
              d_rdata_nx_s = d_rdata_r;
            end
          end else begin
            i_rdy_nx_s = 1'b1;
            if (mem_re_r) begin
              i_rdata_nx_s = bus.mem_rdata;
            end else begin
              i_rdata_nx_s = i_rdata_r;
            end
          end
        end else begin
          mem_re_nx_s = mem_re_r;
          mem_we_nx_s = mem_we_r;
        end
      end
      ARB_RESP: begin
        mem_re_nx_s = 1'b0;
        mem_we_nx_s = 1'b0;
      end
      default: begin
        mem_re_nx_s = 1'b0;
        mem_we_nx_s = 1'b0;
      end
    endcase
  end

  // Output, owner and streak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r     <= OWN_I;
      d_streak_r  <= 4'd0;
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      i_rdata_r   <= '0;
      d_rdata_r   <= '0;
      i_rdy_r     <= 1'b0;
      d_rdy_r     <= 1'b0;
    end else begin
      owner_r     <= owner_nx_s;
      d_streak_r  <= d_streak_nx_s;
      mem_re_r    <= mem_re_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
      i_rdata_r   <= i_rdata_nx_s;
      d_rdata_r   <= d_rdata_nx_s;
      i_rdy_r     <= i_rdy_nx_s;
      d_rdy_r     <= d_rdy_nx_s;
    end
  end

  assign bus.mem_re    = mem_re_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.i_rdy     = i_rdy_r;
  assign bus.d_rdy     = d_rdy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester and memory models, access and response monitors.
module tb_mem_arbiter;

  localparam int AW  = 14;
  localparam int LW  = 64;
  localparam int LIM = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } dreq_t;

  typedef struct {
    logic          side_d;
    logic [LW-1:0] data;
    int            id;
  } resp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            len;
    int            id;
  } acc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   i_rise      = 0;
  int   last_i_lat  = 0;
  int   mem_lat     = 3;
  int   mcnt        = 0;
  logic force_rdy   = 1'b0;

  dreq_t         d_q[$];
  logic [AW-1:0] i_q[$];
  resp_t         resp_q[$];
  acc_t          acc_q[$];
  logic [LW-1:0] mem [logic [AW-1:0]];

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Unknown lines read back as a recognisable address pattern.
  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {16'hA5A5, 34'h0, a};
  endfunction

  // D-side requester: keeps d_req high across back-to-back transactions.
  initial begin
    dreq_t t;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.d_req) begin
        if (d_q.size() > 0) begin
          t = d_q.pop_front();
          bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata; bus.d_req = 1'b1;
        end
      end else if (bus.d_rdy) begin
        if (d_q.size() > 0) begin
          t = d_q.pop_front();
          bus.d_we = t.we; bus.d_addr = t.addr; bus.d_wdata = t.wdata;
        end else begin
          bus.d_req = 1'b0;
        end
      end
    end
  end

  // I-side requester.
  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    forever begin
      @(negedge clk);
      if (!bus.i_req) begin
        if (i_q.size() > 0) begin
          bus.i_addr = i_q.pop_front(); bus.i_req = 1'b1; i_rise = cyc;
        end
      end else if (bus.i_rdy) begin
        if (i_q.size() > 0) begin
          bus.i_addr = i_q.pop_front(); i_rise = cyc;
        end else begin
          bus.i_req = 1'b0;
        end
      end
    end
  end

  // Memory model: completes after mem_lat strobe cycles; force_rdy injects a stray pulse.
  initial begin
    bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt = 0; bus.mem_rdy = 1'b0;
      end else if (force_rdy) begin
        bus.mem_rdy = 1'b1; bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (bus.mem_re || bus.mem_we) begin
        mcnt++;
        if (mcnt == mem_lat) begin
          bus.mem_rdy = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : dflt(bus.mem_addr);
        end else begin
          bus.mem_rdy = 1'b0;
        end
      end else begin
        mcnt = 0; bus.mem_rdy = 1'b0;
      end
    end
  end

  // Access monitor: checks each memory access against the expected grant order.
  initial begin
    logic prev_stb;
    int   len;
    acc_t a;
    prev_stb = 1'b0; len = 0;
    a = '{we: 1'b0, addr: '0, wdata: '0, len: 0, id: -1};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stb = 1'b0; len = 0;
      end else begin
        if ((bus.mem_re || bus.mem_we) && !prev_stb) begin
          len = 1;
          if (acc_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_access: got addr %h, expected none", bus.mem_addr);
          end else begin
            a = acc_q.pop_front();
            check($sformatf("acc%0d_we_re", a.id), {62'b0, bus.mem_we, bus.mem_re}, a.we ? 64'd2 : 64'd1);
            check($sformatf("acc%0d_addr", a.id), {50'b0, bus.mem_addr}, {50'b0, a.addr});
            if (a.we) check($sformatf("acc%0d_wdata", a.id), bus.mem_wdata, a.wdata);
          end
        end else if (bus.mem_re || bus.mem_we) begin
          len++;
        end else if (prev_stb) begin
          check($sformatf("acc%0d_strobe_len", a.id), 64'(len), 64'(a.len));
        end
        prev_stb = bus.mem_re || bus.mem_we;
      end
    end
  end

  // Response monitor: pops the expected completion whenever a rdy pulse is seen.
  initial begin
    resp_t r;
    logic  prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1'b0;
      end else begin
        if (prev_rdy) check("rdy_one_cycle", {62'b0, bus.d_rdy, bus.i_rdy}, 64'd0);
        if (bus.i_rdy || bus.d_rdy) begin
          if (bus.i_rdy) last_i_lat = cyc - i_rise + 1;
          if (resp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_rdy: got i_rdy=%b d_rdy=%b, expected none", bus.i_rdy, bus.d_rdy);
          end else begin
            r = resp_q.pop_front();
            check($sformatf("resp%0d_side", r.id), {62'b0, bus.d_rdy, bus.i_rdy}, r.side_d ? 64'd2 : 64'd1);
            check($sformatf("resp%0d_rdata", r.id), r.side_d ? bus.d_rdata : bus.i_rdata, r.data);
          end
        end
        prev_rdy = bus.i_rdy || bus.d_rdy;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_acc(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                         input int len, input int id);
    acc_q.push_back('{we: we, addr: addr, wdata: wd, len: len, id: id});
  endtask

  task automatic exp_resp(input logic side_d, input logic [LW-1:0] data, input int id);
    resp_q.push_back('{side_d: side_d, data: data, id: id});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((resp_q.size() > 0 || d_q.size() > 0 || i_q.size() > 0 || bus.d_req || bus.i_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", name, resp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {60'b0, bus.i_rdy, bus.d_rdy, bus.mem_re, bus.mem_we}, 64'd0);
    check("reset_addr", {50'b0, bus.mem_addr}, 64'd0);
    check("reset_i_rdata", bus.i_rdata, 64'd0);
    check("reset_d_rdata", bus.d_rdata, 64'd0);
    rst_n = 1'b1;

    // I-only read, latency 3.
    sync();
    mem_lat = 3;
    mem[14'h0123] = 64'hDEAD_BEEF_0000_0001;
    exp_acc(1'b0, 14'h0123, 64'd0, 3, 1);
    exp_resp(1'b0, 64'hDEAD_BEEF_0000_0001, 1);
    i_q.push_back(14'h0123);
    wait_done("t1");
    check("t1_i_latency", 64'(last_i_lat), 64'd5);

    // D read then D write-back; the write must not touch d_rdata.
    sync();
    mem_lat = 2;
    exp_acc(1'b0, 14'h0041, 64'd0, 2, 2);
    exp_resp(1'b1, 64'hA5A5_0000_0000_0041, 2);
    exp_acc(1'b1, 14'h0040, 64'd1, 2, 3);
    exp_resp(1'b1, 64'hA5A5_0000_0000_0041, 3);
    d_q.push_back('{we: 1'b0, addr: 14'h0041, wdata: 64'd0});
    d_q.push_back('{we: 1'b1, addr: 14'h0040, wdata: 64'd1});
    wait_done("t2");

    // Simultaneous requests: D first, I in the IDLE cycle right after RESP.
    sync();
    exp_acc(1'b0, 14'h0200, 64'd0, 2, 4);
    exp_resp(1'b1, 64'hA5A5_0000_0000_0200, 4);
    exp_acc(1'b0, 14'h0100, 64'd0, 2, 5);
    exp_resp(1'b0, 64'hA5A5_0000_0000_0100, 5);
    d_q.push_back('{we: 1'b0, addr: 14'h0200, wdata: 64'd0});
    i_q.push_back(14'h0100);
    wait_done("t3");
    check("t3_i_latency", 64'(last_i_lat), 64'd8);

    // Starvation guard: four D grants, then I, then D resumes.
    sync();
    mem_lat = 1;
    exp_acc(1'b0, 14'h0040, 64'd0, 1, 6);
    exp_resp(1'b1, 64'd1, 6);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) begin
        exp_acc(1'b0, 14'h0300, 64'd0, 1, 20);
        exp_resp(1'b0, 64'hA5A5_0000_0000_0300, 20);
      end
      exp_acc(1'b0, 14'(14'h0400 + k), 64'd0, 1, 6 + k);
      exp_resp(1'b1, {16'hA5A5, 34'h0, 14'(14'h0400 + k)}, 6 + k);
    end
    d_q.push_back('{we: 1'b0, addr: 14'h0040, wdata: 64'd0});
    for (int k = 1; k <= 5; k++) d_q.push_back('{we: 1'b0, addr: 14'(14'h0400 + k), wdata: 64'd0});
    i_q.push_back(14'h0300);
    wait_done("t4");

    // Reset two cycles into a D read; the access re-runs once released.
    sync();
    mem_lat = 4;
    exp_acc(1'b0, 14'h0500, 64'd0, 4, 30);
    exp_acc(1'b0, 14'h0500, 64'd0, 4, 31);
    exp_resp(1'b1, 64'hA5A5_0000_0000_0500, 31);
    d_q.push_back('{we: 1'b0, addr: 14'h0500, wdata: 64'd0});
    n = 0;
    while (!bus.mem_re && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_read_started", {63'b0, bus.mem_re}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {60'b0, bus.i_rdy, bus.d_rdy, bus.mem_re, bus.mem_we}, 64'd0);
    check("t5_rst_addr", {50'b0, bus.mem_addr}, 64'd0);
    check("t5_rst_d_rdata", bus.d_rdata, 64'd0);
    check("t5_rst_i_rdata", bus.i_rdata, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_done("t5");

    // Stray mem_rdy in IDLE must be ignored.
    sync();
    force_rdy = 1'b1;
    sync();
    force_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_idle_quiet%0d", k), {60'b0, bus.i_rdy, bus.d_rdy, bus.mem_re, bus.mem_we}, 64'd0);
    end
    sync();
    mem_lat = 2;
    exp_acc(1'b0, 14'h0600, 64'd0, 2, 40);
    exp_resp(1'b0, 64'hA5A5_0000_0000_0600, 40);
    i_q.push_back(14'h0600);
    wait_done("t6");
    check("t6_i_latency", 64'(last_i_lat), 64'd4);
    check("acc_q_drained", 64'(acc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified main-memory port between the instruction-cache fill path (I-side, read only) and the data-cache miss/write-back path (D-side, read or write).
- Sits between both cache controllers and main memory. The pipeline stalls on each side until that side's ready pulse arrives.
- D-side has priority. A starvation guard guarantees I-side forward progress.

Parameters:
- ADDR_W, 14, line address width in bits.
- LINE_W, 64, cache line / memory data width in bits.
- STARVE_LIM, 4, maximum consecutive D grants allowed while i_req is pending; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  I-side request. Held high until i_rdy is seen.
- i_addr  input  ADDR_W  I-side line address. Stable while i_req is high.
- i_rdata  output  LINE_W  I-side fill data. Valid in the i_rdy cycle.
- i_rdy  output  1  one-cycle completion pulse for the I-side.
- d_req  input  1  D-side request. Held high until d_rdy is seen.
- d_we  input  1  D-side direction: 1 = write-back, 0 = fill.
- d_addr  input  ADDR_W  D-side line address.
- d_wdata  input  LINE_W  D-side write-back data.
- d_rdata  output  LINE_W  D-side fill data. Valid in the d_rdy cycle.
- d_rdy  output  1  one-cycle completion pulse for the D-side.
- mem_re  output  1  memory read strobe, held for the whole access.
- mem_we  output  1  memory write strobe, held for the whole access.
- mem_addr  output  ADDR_W  memory line address.
- mem_wdata  output  LINE_W  memory write data.
- mem_rdata  input  LINE_W  memory read data. Valid when mem_rdy=1.
- mem_rdy  input  1  memory completion, one cycle. Variable latency, at least 1 cycle after the strobe rises.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs are registered and reset to 0; state = IDLE; d_streak = 0.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE:
  - Grant decision is made at every rising edge.
  - d_req only → D_BUSY.
  - i_req only → I_BUSY.
  - Both requests, d_streak < STARVE_LIM → D_BUSY.
  - Both requests, d_streak == STARVE_LIM → I_BUSY.
  - Neither → stay in IDLE.
- On entry to a BUSY state, at the granting edge:
  - Register mem_addr from the winner.
  - For D, register mem_wdata = d_wdata, mem_we = d_we, mem_re = ~d_we.
  - For I, set mem_re = 1, mem_we = 0.
  - Latch the owner (I or D).
- BUSY states:
  - Strobes, address and write data are held constant.
  - On mem_rdy, at the edge: drop both strobes and go to RESP.
  - If the access was a read, capture mem_rdata into the owner's rdata register.
  - mem_rdy seen outside a BUSY state is ignored.
- RESP:
  - Owner's rdy = 1 for exactly one cycle, then → IDLE.
  - A requester drops its req in the cycle after its rdy. So the earliest re-grant is the IDLE cycle after RESP; there is no back-to-back re-grant of a stale request.
- Rdata hold: i_rdata and d_rdata hold their value until the next read completion on that side. A D write leaves d_rdata unchanged.
- Minimum turnaround: req→rdy = memory latency + 2 cycles. Grant edge, then memory latency, then the RESP cycle.
- Starvation counter d_streak (4 bits), updated at the grant edge:
  - D grant with i_req=1 → +1, saturating at STARVE_LIM.
  - D grant with i_req=0 → 0.
  - I grant → 0.
- Request changes while busy: requests arriving or changing during BUSY or RESP are ignored until IDLE. Changing addr, data or we while req is high is illegal (requester contract); the arbiter uses only the values latched at grant.
- Reset mid-transaction: FSM, strobes and the rdy pulses clear immediately. No rdy pulse is issued for the aborted access. Main memory is reset by the same rst_n.
- Mutual exclusion: mem_re and mem_we are never both 1. i_rdy and d_rdy are never both 1.

Decomposition:
- defines.v additions:
  - `ARB_IDLE, `ARB_I_BUSY, `ARB_D_BUSY, `ARB_RESP as 2-bit encodings.
  - `OWN_I / `OWN_D owner encodings.
- Optional sub-module arb_grant: purely combinational winner select from i_req, d_req, d_streak and STARVE_LIM. Allows the fairness rule to be unit-tested alone.
- All state registers remain in mem_arbiter.

Test Plan:
- I-only read, memory latency 3, i_addr=14'h0123, mem_rdata=64'hDEAD_BEEF_0000_0001 → mem_re high 3 cycles with mem_addr=0123; i_rdy pulses once, 5 cycles after i_req, with i_rdata=DEAD_BEEF_0000_0001; d_rdy stays 0.
- D write-back, d_we=1, d_addr=14'h0040, d_wdata=64'h1 → mem_we=1, mem_re=0, mem_wdata=1; d_rdy single pulse; d_rdata unchanged.
- i_req and d_req rise in the same cycle → D granted first. After d_rdy, I is granted in the IDLE cycle following RESP.
- i_req held high and d_req re-asserted immediately after each d_rdy, STARVE_LIM=4 → exactly 4 D accesses, then 1 I access, then D resumes; d_streak returns to 0.
- rst_n pulled low 2 cycles into a D read → all outputs 0 immediately; no d_rdy. After release with d_req still high, the access re-runs cleanly.
- mem_rdy pulsed while in IDLE → no state change, no rdy pulse.
